dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Initiator side of the data-memory interface. Sits between the MEM pipeline stage and a
//  16-bit byte-addressed data memory that can stall. Accepts one load/store per handshake,
//  issues it to memory, waits for completion, and returns read data or an error.
//  Checks word alignment and watches for memory timeouts. Stalls the pipeline via busy.
// PARAMETERS
//  ADDR_W   16   address width in bits
//  DATA_W   16   data width in bits
//  TIMEOUT  255  max cycles in WAIT before error; range 1..255; 8-bit counter
// PORTS
//  clk         in   1       clock; all state changes on the rising edge
//  rst         in   1       synchronous, active-high reset
//  req_valid   in   1       pipeline presents a request
//  req_ready   out  1       controller idle; request accepted when valid&ready
//  req_wr      in   1       1 = store, 0 = load
//  req_addr    in   ADDR_W  byte address; must be even
//  req_wdata   in   DATA_W  store data, {byte[addr], byte[addr+1]}
//  resp_valid  out  1       one-cycle pulse: request complete
//  resp_rdata  out  DATA_W  load data; valid with resp_valid
//  resp_err    out  1       with resp_valid: misaligned (addr[0]=1) or timeout
//  busy        out  1       request in flight (state != IDLE); pipeline stall
//  mem_rd      out  1       memory read strobe
//  mem_wr      out  1       memory write strobe
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data; sampled when mem_done=1
//  mem_stall   in   1       memory refuses the strobe this cycle; hold and retry
//  mem_done    in   1       memory completed the accepted access
// BEHAVIOUR
//  Reset: state=IDLE, counter=0; all outputs 0 while rst=1.
//   req_ready rises the first cycle after rst drops.
//  States:
//   IDLE:  req_ready=1. On valid&ready, latch wr/addr/wdata.
//          If addr[0]=1 -> RESP with err=1; memory is never touched.
//          Otherwise -> ISSUE.
//   ISSUE: drive mem_rd=~wr, mem_wr=wr, mem_addr and mem_wdata from the latches.
//          mem_stall=1 -> stay in ISSUE with strobe and operands unchanged.
//          mem_stall=0 & mem_done=1 -> capture rdata, go to RESP.
//          mem_stall=0 & mem_done=0 -> go to WAIT, counter=0.
//   WAIT:  strobes low. mem_done=1 -> capture rdata, go to RESP.
//          Else counter+1; counter reaches TIMEOUT -> RESP with err=1.
//          mem_done and timeout in the same cycle: mem_done wins, err=0.
//   RESP:  resp_valid=1 for exactly one cycle; then go to IDLE. req_ready=0 in this state.
//  Response data:
//   Store response: resp_rdata=0.
//   Error response: resp_rdata=0.
//   resp_rdata/resp_err hold their values until the next resp_valid.
//  Strobes:
//   mem_rd and mem_wr are never both 1.
//   mem_rd/mem_wr are 0 in every state except ISSUE.
//   mem_addr/mem_wdata hold their last values outside ISSUE.
//  Ignored inputs: mem_done outside ISSUE/WAIT; req_valid when not in IDLE.
//  Latency from accept edge to resp_valid (aligned, no stall):
//   2 cycles if done in ISSUE; 2+N cycles if done after N WAIT cycles.
//   Misaligned: 1 cycle.
//  Back-to-back: a new request can be accepted the cycle after RESP; one request in flight.
//  Reset mid-operation: request abandoned, strobes low next cycle, no resp_valid.
// TESTING
//  1 Load addr=0x0010, mem_done in ISSUE, rdata=0xBEEF ->
//    resp_valid 2 cycles after accept, rdata=0xBEEF, err=0.
//  2 Store addr=0x0020, wdata=0x1234, mem_stall=1 for 3 cycles ->
//    mem_wr held 4 cycles with stable addr/data; resp_valid with err=0, rdata=0.
//  3 Load addr=0x0033 (odd) -> resp_valid 1 cycle after accept, err=1;
//    mem_rd/mem_wr never asserted.
//  4 Load, TIMEOUT=4, mem_done never asserted -> err=1 after 4 WAIT cycles;
//    also check mem_done on the 4th cycle -> err=0.
//  5 Two back-to-back loads (0x0002, 0x0004) -> second accepted the cycle after first RESP;
//    busy low only in IDLE.
//  6 rst pulsed during WAIT -> no resp_valid; req_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Bundles the pipeline request/response handshake and the data-memory bus of dmem_access_ctrl.
// The slave modport is the controller's view; master is the pipeline+memory side.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;
  logic              mem_done;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_stall, mem_done,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_stall, mem_done,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: one load/store in flight, alignment check, stall retry and
// completion timeout; busy stalls the pipeline while a request is outstanding.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_access_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_inc;
  logic              timeout_hit;
  logic [DATA_W-1:0] load_data;

  assign cnt_inc     = cnt_q + 8'd1;
  assign timeout_hit = (cnt_inc == TIMEOUT_C);
  assign load_data   = wr_q ? '0 : bus.mem_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) state_d = bus.req_addr[0] ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (!bus.mem_stall) state_d = bus.mem_done ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_done || timeout_hit) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Memory operands load only on aligned accepts so the bus holds its last values elsewhere.
  // Response registers change only on entry to RESP, so they hold between responses.
  always_comb begin
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          wr_d = bus.req_wr;
          if (bus.req_addr[0]) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata;
          end
        end
      end
      S_ISSUE: begin
        if (!bus.mem_stall) begin
          if (bus.mem_done) begin
            rdata_d = load_data;
            err_d   = 1'b0;
          end else begin
            cnt_d = '0;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_done) begin
          rdata_d = load_data;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs; rst forces everything low during reset
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    if (!rst) begin
      bus.req_ready  = (state_q == S_IDLE);
      bus.busy       = (state_q != S_IDLE);
      bus.resp_valid = (state_q == S_RESP);
      bus.mem_rd     = (state_q == S_ISSUE) && !wr_q;
      bus.mem_wr     = (state_q == S_ISSUE) &&  wr_q;
      bus.mem_addr   = mem_addr_q;
      bus.mem_wdata  = mem_wdata_q;
      bus.resp_rdata = rdata_q;
      bus.resp_err   = err_q;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl: acts as pipeline and memory, predicting each
// transaction's latency, error and data from stall/done timing.
module tb_dmem_access_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   last_wait;

  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dmem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Runs one request starting at a negedge. S = stall cycles on the strobe,
  // D = done delay (0: in the issue cycle, k: in the k-th wait cycle, >TO: never).
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int S, input int D, input bit idle_after);
    int exp_lat, exp_str, lat, nstrobe, nwait, waited;
    bit exp_err, got, viol, busy_bad, strobe;
    logic [15:0] exp_rd, rd_seen;
    logic err_seen;

    if (addr[0]) begin
      exp_lat = 1; exp_err = 1'b1; exp_str = 0;
    end else begin
      exp_str = S + 1;
      if (D == 0)       begin exp_lat = S + 2;      exp_err = 1'b0; end
      else if (D <= TO) begin exp_lat = S + 2 + D;  exp_err = 1'b0; end
      else              begin exp_lat = S + 2 + TO; exp_err = 1'b1; end
    end
    exp_rd = (wr || exp_err) ? 16'h0 : rdata;

    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    waited = 0;
    while (!bus.req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    last_wait = waited;
    if (!bus.req_ready) begin
      check("accept_timeout", 32'(waited), 32'd0);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 16'($urandom);

    got = 1'b0; viol = 1'b0; busy_bad = 1'b0;
    nstrobe = 0; nwait = 0; lat = 0; rd_seen = '0; err_seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (!bus.busy || bus.req_ready) busy_bad = 1'b1;
      if (bus.mem_rd && bus.mem_wr) viol = 1'b1;
      strobe = bus.mem_rd || bus.mem_wr;
      if (strobe && (bus.mem_wr != wr || bus.mem_addr != addr || bus.mem_wdata != wdata))
        viol = 1'b1;
      if (bus.resp_valid) begin
        lat = c; got = 1'b1;
        rd_seen = bus.resp_rdata; err_seen = bus.resp_err;
        bus.mem_stall = 1'b0;
        bus.mem_done  = 1'b0;
        break;
      end
      if (strobe) begin
        nstrobe++;
        bus.mem_stall = (nstrobe <= S);
        bus.mem_done  = !bus.mem_stall && (D == 0);
      end else begin
        nwait++;
        bus.mem_stall = 1'($urandom);
        bus.mem_done  = (nwait == D);
      end
      bus.mem_rdata = bus.mem_done ? rdata : 16'($urandom);
      @(negedge clk);
    end

    check("resp_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(err_seen), 32'(exp_err));
    check("resp_rdata", 32'(rd_seen), 32'(exp_rd));
    check("strobe_cycles", 32'(nstrobe), 32'(exp_str));
    check("strobe_rules", 32'(viol), 32'd0);
    check("busy_in_flight", 32'(busy_bad), 32'd0);

    if (idle_after) begin
      @(negedge clk);
      bus.mem_done = 1'($urandom);
      check("idle_ready", {bus.req_ready, bus.busy, bus.resp_valid}, 32'b100);
      check("resp_hold", {bus.resp_err, bus.resp_rdata}, {exp_err, exp_rd});
    end
  endtask

  initial begin
    bit b2b_bad;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_rdata = '0;   bus.mem_stall = 1'b0; bus.mem_done = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.req_ready, bus.busy, bus.resp_valid, bus.mem_rd,
                            bus.mem_wr, bus.resp_err, bus.resp_rdata, bus.mem_addr}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(bus.req_ready), 32'd1);

    // Directed cases
    run_txn(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0, 1'b1);
    run_txn(1'b1, 16'h0020, 16'h1234, 16'h5555, 3, 0, 1'b1);
    run_txn(1'b0, 16'h0033, 16'h0000, 16'hAAAA, 0, 0, 1'b1);
    run_txn(1'b0, 16'h0040, 16'h0000, 16'h7777, 0, 99, 1'b1);
    run_txn(1'b0, 16'h0042, 16'h0000, 16'h6666, 0, TO, 1'b1);
    run_txn(1'b0, 16'h0002, 16'h0000, 16'h0102, 0, 0, 1'b0);
    run_txn(1'b0, 16'h0004, 16'h0000, 16'h0304, 0, 1, 1'b1);
    check("back_to_back_wait", 32'(last_wait), 32'd1);

    // Reset during WAIT: abandon, no response
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 16'h0080;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.mem_stall = 1'b0; bus.mem_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_mid_wait", {bus.busy, bus.resp_valid, bus.mem_rd, bus.req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_mid_reset", 32'(bus.req_ready), 32'd1);
    b2b_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bus.mem_done = 1'($urandom);
      if (bus.resp_valid || bus.busy) b2b_bad = 1'b1;
    end
    check("no_resp_after_reset", 32'(b2b_bad), 32'd0);
    bus.mem_done = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [15:0] a;
      int r, d;
      a = 16'($urandom);
      if ($urandom_range(3) != 0) a[0] = 1'b0;
      r = int'($urandom_range(7));
      d = (r <= 5) ? r : 0;
      run_txn(1'($urandom), a, 16'($urandom), 16'($urandom),
              int'($urandom_range(3)), d, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
